// File: rtl/seg7_pkg.sv
// Shared glyph table and sizing for the seven-segment scan driver.
// Glyph bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high segment pattern.
// Non-decimal nibbles show a dash; blank overrides everything.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    unique case (1'b1)
      blank:                    seg = GLYPH_BLANK;
      (!blank && digit > 4'd9): seg = GLYPH_DASH;
      default:                  seg = glyph_of(digit);
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-aligned reload.
// Define SEG7_LZ_BLANK_EN to blank leading zeros on digits 3..1.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        Clk,
  input  logic        RST,
  input  logic [15:0] DIGITS_IN,
  input  logic        LOAD,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        FRAME_DONE
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  // XOR masks: all-ones inverts to active-low, also the "off" level
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pend_valid;
  logic          tick;
  logic          boundary;
  logic [3:0]    cur;
  logic          lz_blank;
  logic [6:0]    seg_raw;

  assign tick     = (presc == LAST);
  assign boundary = tick && (idx == IDX_LAST);
  assign cur      = disp[{idx, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    unique case (idx)
      2'd1:    lz_blank = (disp[15:4] == 12'h000);
      2'd2:    lz_blank = (disp[15:8] == 8'h00);
      2'd3:    lz_blank = (disp[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  bcd_to_seg7 u_dec (
    .digit (cur),
    .blank (lz_blank),
    .seg   (seg_raw)
  );

  always_ff @(posedge Clk) begin
    if (RST) begin
      presc      <= '0;
      idx        <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      SEG        <= SEG_OFF;
      AN         <= AN_OFF;
      FRAME_DONE <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + PW'(1);
      FRAME_DONE <= boundary;
      SEG        <= seg_raw ^ SEG_OFF;
      AN         <= (4'b0001 << idx) ^ AN_OFF;
      if (tick) begin
        idx <= idx + IW'(1);
      end
      // display only ever changes on the frame boundary
      if (boundary && LOAD) begin
        disp       <= DIGITS_IN;
        pend_valid <= 1'b0;
      end else if (boundary && pend_valid) begin
        disp       <= pend;
        pend_valid <= 1'b0;
      end else if (LOAD) begin
        pend       <= DIGITS_IN;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at SCAN_DIV=4, active-high.
// Honors SEG7_LZ_BLANK_EN for expected leading-zero blanking.
module tb_seg7_scan_driver;

  logic        Clk = 1'b0;
  logic        RST;
  logic [15:0] DIGITS_IN;
  logic        LOAD;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        FRAME_DONE;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .SCAN_DIV   (4),
    .ACTIVE_LOW (1'b0)
  ) u_dut (
    .Clk        (Clk),
    .RST        (RST),
    .DIGITS_IN  (DIGITS_IN),
    .LOAD       (LOAD),
    .SEG        (SEG),
    .AN         (AN),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [3:0]  n;
    logic [15:0] hi;
    n  = v[d*4 +: 4];
    hi = v >> (4 * d);
`ifdef SEG7_LZ_BLANK_EN
    if (d > 0 && hi == 16'h0) return 7'h00;
`else
    if (hi == 16'hFFFF) return 7'h00;
`endif
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Steps 1..nsteps of a frame showing disp; optional LOAD after step ld_step.
  task automatic run_frame(input logic [15:0] disp, input int ld_step,
                           input logic [15:0] ld_val, input int nsteps);
    int d;
    for (int s = 1; s <= nsteps; s++) begin
      @(negedge Clk);
      d = (s - 1) / 4;
      chk($sformatf("seg %h s%0d", disp, s), 32'(SEG), 32'(exp_seg(disp, d)));
      chk($sformatf("an %h s%0d", disp, s), 32'(AN), 32'(4'b0001 << d));
      chk($sformatf("fd %h s%0d", disp, s), 32'(FRAME_DONE), 32'(s == 16));
      LOAD = 1'b0;
      if (s == ld_step) begin
        LOAD      = 1'b1;
        DIGITS_IN = ld_val;
      end
    end
  endtask

  task automatic chk_off(input string tag);
    @(negedge Clk);
    chk({tag, " seg"}, 32'(SEG), 32'h0);
    chk({tag, " an"}, 32'(AN), 32'h0);
    chk({tag, " fd"}, 32'(FRAME_DONE), 32'h0);
  endtask

  initial begin
    RST       = 1'b1;
    LOAD      = 1'b0;
    DIGITS_IN = 16'h0;
    @(negedge Clk);
    chk_off("rst0");
    chk_off("rst1");
    RST       = 1'b0;
    LOAD      = 1'b1;
    DIGITS_IN = 16'h1234;
    run_frame(16'h0000, 0, 16'h0, 16);
    run_frame(16'h1234, 6, 16'h5678, 16);
    run_frame(16'h5678, 15, 16'h9999, 16);
    chk("pend clr", 32'(u_dut.pend_valid), 32'h0);
    run_frame(16'h9999, 3, 16'h00A7, 16);
    run_frame(16'h00A7, 2, 16'h0007, 16);
    run_frame(16'h0007, 2, 16'h4321, 8);
    RST  = 1'b1;
    LOAD = 1'b0;
    chk_off("mid rst0");
    chk_off("mid rst1");
    RST = 1'b0;
    run_frame(16'h0000, 0, 16'h0, 16);
    run_frame(16'h0000, 0, 16'h0, 16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
